// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Runtime-programmable controller for a counter-based clock divider. It holds
// the active divide ratio and high-phase length and accepts new settings over
// a valid/ready handshake. While running, a new setting is staged and only
// applied when the period wraps, so clk_out never glitches.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   run request (level); a period in progress always completes
//   cfg_valid  in   configuration offered
//   cfg_ready  out  configuration can be accepted (no staged setting waiting)
//   cfg_div    in   requested period in clk cycles (>= 2)
//   cfg_high   in   requested high-phase cycles (1 .. cfg_div-1)
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse on the last cycle of each period
//   busy       out  a staged configuration is waiting for a period boundary
//   cfg_err    out  one-cycle pulse after an offered configuration is rejected
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned CNT_W    = 13,
    parameter int unsigned DEF_DIV  = 5000,
    parameter int unsigned DEF_HIGH = 2500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One divider setting: period length and high-phase length.
    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam cfg_t             DEF_CFG = '{div: CNT_W'(DEF_DIV), high: CNT_W'(DEF_HIGH)};

    // Registered state
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    cfg_t             r_act;
    cfg_t             r_pend_cfg;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_busy;
    logic             r_cfg_ready;
    logic             r_cfg_err;

    // Next-state and decode
    state_t           w_state_n;
    logic [CNT_W-1:0] w_count_n;
    cfg_t             w_act_n;
    cfg_t             w_pend_cfg_n;
    logic             w_pend_n;
    logic             w_clk_out_n;
    logic             w_tick_n;
    logic             w_cfg_err_n;
    cfg_t             w_offer;
    logic             w_accept;
    logic             w_cfg_ok;
    logic             w_wrap;

    assign w_offer  = '{div: cfg_div, high: cfg_high};
    assign w_accept = cfg_valid && !r_pend;
    // Unsigned check: div >= 2 and 1 <= high <= div-1.
    assign w_cfg_ok = (cfg_div >= TWO) && (cfg_high != '0) && (cfg_high < cfg_div);
    assign w_wrap   = (r_count == (r_act.div - ONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state / datapath: settings only change in IDLE or at a period wrap.
    always_comb begin
        w_state_n    = r_state;
        w_count_n    = r_count;
        w_act_n      = r_act;
        w_pend_cfg_n = r_pend_cfg;
        w_pend_n     = r_pend;
        case (r_state)
            IDLE: begin
                w_count_n = '0;
                if (w_accept && w_cfg_ok) begin
                    w_act_n = w_offer;
                end
                if (en) begin
                    w_state_n = RUN;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_count_n = '0;
                    // A setting offered on the wrap cycle wins over nothing staged;
                    // the two cannot coexist because cfg_ready is low while staged.
                    if (w_accept && w_cfg_ok) begin
                        w_act_n = w_offer;
                    end else if (r_pend) begin
                        w_act_n  = r_pend_cfg;
                        w_pend_n = 1'b0;
                    end
                    if (!en) begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_count_n = r_count + ONE;
                    if (w_accept && w_cfg_ok) begin
                        w_pend_cfg_n = w_offer;
                        w_pend_n     = 1'b1;
                    end
                end
            end
        endcase
    end

    // Output decode from next-state values so the registered outputs line up with count.
    always_comb begin
        w_clk_out_n = 1'b0;
        w_tick_n    = 1'b0;
        w_cfg_err_n = w_accept && !w_cfg_ok;
        if (w_state_n == RUN) begin
            w_clk_out_n = (w_count_n < w_act_n.high);
            w_tick_n    = (w_count_n == (w_act_n.div - ONE));
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_act       <= DEF_CFG;
            r_pend_cfg  <= DEF_CFG;
            r_pend      <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_count     <= w_count_n;
            r_act       <= w_act_n;
            r_pend_cfg  <= w_pend_cfg_n;
            r_pend      <= w_pend_n;
            r_clk_out   <= w_clk_out_n;
            r_tick      <= w_tick_n;
            r_busy      <= w_pend_n;
            r_cfg_ready <= !w_pend_n;
            r_cfg_err   <= w_cfg_err_n;
        end
    end

    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl: table-driven configuration vectors,
// hand-written multi-cycle sequences and a randomized phase, all checked
// against a period-level reference model of the divider.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 13;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: the running period (div/high), position inside it,
    // and an optional staged setting for the next period.
    bit m_run;
    bit m_pend;
    bit m_err;
    bit m_acc;
    bit m_good;
    int m_pos;
    int m_div;
    int m_high;
    int m_pdiv;
    int m_phigh;

    typedef struct {
        int div;
        int high;
        bit err;
    } vec_t;

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (5000),
        .DEF_HIGH(2500)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model update once per clock, from the rules of a period-based divider.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_div  = 5000;
            m_high = 2500;
            m_pend = 1'b0;
            m_err  = 1'b0;
            m_pdiv = 0;
            m_phigh = 0;
        end else begin
            m_acc  = cfg_valid && !m_pend;
            m_good = (int'(cfg_div) >= 2) && (int'(cfg_high) >= 1) && (int'(cfg_high) < int'(cfg_div));
            m_err  = m_acc && !m_good;
            if (!m_run) begin
                if (m_acc && m_good) begin
                    m_div  = int'(cfg_div);
                    m_high = int'(cfg_high);
                end
                m_pos = 0;
                m_run = en;
            end else if (m_pos == m_div - 1) begin
                if (m_acc && m_good) begin
                    m_div  = int'(cfg_div);
                    m_high = int'(cfg_high);
                end else if (m_pend) begin
                    m_div  = m_pdiv;
                    m_high = m_phigh;
                    m_pend = 1'b0;
                end
                m_pos = 0;
                m_run = en;
            end else begin
                m_pos = m_pos + 1;
                if (m_acc && m_good) begin
                    m_pdiv  = int'(cfg_div);
                    m_phigh = int'(cfg_high);
                    m_pend  = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_clk_out",   32'(clk_out),   32'(m_run && (m_pos < m_high)));
            chk("model_tick",      32'(tick),      32'(m_run && (m_pos == m_div - 1)));
            chk("model_busy",      32'(busy),      32'(m_pend));
            chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
            chk("model_cfg_err",   32'(cfg_err),   32'(m_err));
        end
    end

    // Present a configuration for one cycle; returns on the following negedge.
    task automatic offer(input int d, input int h);
        cfg_div   = CNT_W'(d);
        cfg_high  = CNT_W'(h);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Wait (bounded) until the model is running period d at position p.
    task automatic wait_at(input int d, input int p, input int maxc, input string name);
        int k;
        for (k = 0; k < maxc; k++) begin
            if (m_run && (m_div == d) && (m_pos == p)) break;
            @(negedge clk);
        end
        n_total++;
        if (k < maxc) n_pass++;
        else $display("FAIL wait_%s: timeout after %0d cycles waiting for div %0d pos %0d", name, maxc, d, p);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t bad[3];
        bit   pat_clk[4];
        int   highs;
        int   ticks;
        int   d;

        tbl = '{'{1, 0, 1}, '{1, 1, 1}, '{6, 0, 1}, '{6, 6, 1}, '{0, 0, 1},
                '{2, 1, 0}, '{8191, 8190, 0}, '{7, 7, 1}, '{7, 9, 1}, '{4, 1, 0}};
        bad = '{'{1, 0, 1}, '{6, 0, 1}, '{6, 6, 1}};
        pat_clk = '{1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
        repeat (3) @(negedge clk);
        chk("rst_clk_out",   32'(clk_out),   32'(0));
        chk("rst_tick",      32'(tick),      32'(0));
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_cfg_err",   32'(cfg_err),   32'(0));
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Default 5000/2500 divider over two full periods.
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("def_first_high", 32'(clk_out), 32'(1));
        highs = int'(clk_out);
        ticks = int'(tick);
        for (int i = 1; i < 10000; i++) begin
            @(negedge clk);
            highs += int'(clk_out);
            ticks += int'(tick);
        end
        chk("def_last_tick", 32'(tick), 32'(1));
        chk("def_high_cycles", 32'(highs), 32'(5000));
        chk("def_ticks", 32'(ticks), 32'(2));

        // Asynchronous reset in the high phase forces reset values at once.
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_clk_out",   32'(clk_out),   32'(0));
        chk("midrst_tick",      32'(tick),      32'(0));
        chk("midrst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("midrst_busy",      32'(busy),      32'(0));
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Configuration vectors offered in IDLE.
        for (int i = 0; i < 10; i++) begin
            offer(tbl[i].div, tbl[i].high);
            chk($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
            @(negedge clk);
            chk($sformatf("tbl%0d_err_clear", i), 32'(cfg_err), 32'(0));
        end

        // 4/1 loaded in IDLE: 1,0,0,0 with tick on the fourth cycle.
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("div4_clk%0d", i), 32'(clk_out), 32'(pat_clk[i % 4]));
            chk($sformatf("div4_tick%0d", i), 32'(tick), 32'((i % 4) == 3));
        end

        // Mid-period reconfigure of a 10/5 period to 6/3.
        offer(10, 5);
        wait_at(10, 2, 100, "mid");
        offer(6, 3);
        chk("mid_busy", 32'(busy), 32'(1));
        chk("mid_ready", 32'(cfg_ready), 32'(0));
        offer(7, 2);
        chk("mid_busy_hold", 32'(busy), 32'(1));
        repeat (5) @(negedge clk);
        chk("mid_old_tick", 32'(tick), 32'(1));
        chk("mid_busy_at_wrap", 32'(busy), 32'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("mid_new_clk%0d", i), 32'(clk_out), 32'(i < 3));
            chk($sformatf("mid_new_tick%0d", i), 32'(tick), 32'(i == 5));
            chk($sformatf("mid_new_busy%0d", i), 32'(busy), 32'(0));
        end

        // Offer on the wrap cycle: next period already 8/2, busy never set.
        wait_at(6, 5, 20, "bnd");
        offer(8, 2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bnd_clk%0d", i), 32'(clk_out), 32'(i < 2));
            chk($sformatf("bnd_tick%0d", i), 32'(tick), 32'(i == 7));
            chk($sformatf("bnd_busy%0d", i), 32'(busy), 32'(0));
        end

        // Invalid offers while running: single-cycle cfg_err, period unchanged.
        for (int i = 0; i < 3; i++) begin
            offer(bad[i].div, bad[i].high);
            chk($sformatf("run_bad%0d_err", i), 32'(cfg_err), 32'(1));
            @(negedge clk);
            chk($sformatf("run_bad%0d_clear", i), 32'(cfg_err), 32'(0));
        end

        // Graceful stop at count 3 of a 10/5 period.
        offer(10, 5);
        wait_at(10, 3, 100, "stop");
        en = 1'b0;
        for (int c = 4; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stop_clk_c%0d", c), 32'(clk_out), 32'(c < 5));
            chk($sformatf("stop_tick_c%0d", c), 32'(tick), 32'(c == 9));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stop_idle_clk%0d", i), 32'(clk_out), 32'(0));
            chk($sformatf("stop_idle_tick%0d", i), 32'(tick), 32'(0));
        end

        // Drop en at count 3, restore at count 5: no gap at the boundary.
        en = 1'b1;
        wait_at(10, 3, 50, "re3");
        en = 1'b0;
        wait_at(10, 5, 50, "re5");
        en = 1'b1;
        repeat (4) @(negedge clk);
        chk("reen_tick", 32'(tick), 32'(1));
        @(negedge clk);
        chk("reen_no_gap", 32'(clk_out), 32'(1));

        // Randomized traffic with small ratios, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            en        = ($urandom_range(9, 0) != 0);
            cfg_valid = ($urandom_range(7, 0) == 0);
            d         = int'($urandom_range(20, 0));
            cfg_div   = CNT_W'(d);
            cfg_high  = CNT_W'($urandom_range(32'(d + 1), 0));
        end
        cfg_valid = 1'b0;
        en        = 1'b0;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable controller for the team's counter-based clock divider. It holds the active divide ratio and high-phase length and accepts new settings over a valid/ready handshake. New settings take effect only at a period boundary, so the generated clock never glitches. It also provides graceful enable/disable, a one-cycle `tick` per period, and a `busy` flag. It sits between the system configuration logic and the slow-clock consumers, such as the display/scan logic.

Parameters:
- CNT_W, 13, width of counter and configuration fields.
- DEF_DIV, 5000, divide ratio loaded at reset (must be >= 2 and < 2^CNT_W).
- DEF_HIGH, 2500, high-phase length loaded at reset (1 <= DEF_HIGH <= DEF_DIV-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_div  in  CNT_W  requested period in clk cycles.
- cfg_high  in  CNT_W  requested high-phase cycles.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the last cycle of each period.
- busy  out  1  a staged configuration is waiting for a boundary.
- cfg_err  out  1  one-cycle pulse when an offered configuration is rejected.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, count = 0, div_r = DEF_DIV, high_r = DEF_HIGH, no pending configuration.
  - clk_out = 0, tick = 0, cfg_ready = 1, busy = 0, cfg_err = 0.
  - Reset mid-run forces these values immediately. No partial period completes.
- Registered internal state: count, active div_r/high_r, and pending div_p/high_p with a pend flag.
- cfg_ready = !pend.
- A configuration is accepted when cfg_valid && cfg_ready on a rising edge.
- Validity rule: cfg_div >= 2 and 1 <= cfg_high <= cfg_div-1.
  - Invalid: cfg_err pulses high the next cycle; the configuration is dropped; active and pending state are unchanged.
  - Valid: cfg_err stays 0.
- State machine:
  - IDLE:
    - clk_out = 0, tick = 0, count held at 0.
    - A valid configuration accepted in IDLE loads div_r/high_r directly; pend stays 0.
    - en = 1 moves to RUN next cycle. The first RUN cycle has count = 0, clk_out = 1.
  - RUN:
    - count increments each cycle and wraps from div_r-1 to 0.
    - clk_out = (count < high_r), computed from next-state values so it is aligned with count and glitch-free.
    - tick = 1 exactly in the cycle where count == div_r-1.
    - A valid configuration accepted while count != div_r-1 is staged (pend = 1, busy = 1).
  - Boundary (RUN, count == div_r-1):
    - If a configuration is accepted in this same cycle, it is applied directly at this boundary.
    - Otherwise, if pend = 1, div_p/high_p are applied and pend clears.
    - The next cycle starts the new period with count = 0.
    - If en = 0 at the boundary, the next state is IDLE (clk_out = 0). Any pending configuration is still applied first.
- en deassert mid-period does not truncate the period; the current period completes.
- en reasserted before the boundary: keeps running without a gap.
- busy = pend.
- Arithmetic: all comparisons are unsigned CNT_W-bit. The counter never exceeds div_r-1, including immediately after a shrink, because new values only load at count wrap.
- Latency:
  - Config accept to effect: 1 cycle in IDLE; up to div_r cycles in RUN.
  - en to first clk_out high: 1 cycle.

Test Plan:
- Reset defaults: assert rst_n = 0 mid-run → clk_out = 0, tick = 0, cfg_ready = 1, busy = 0 immediately. Release, then en = 1 → 2500 cycles high, 2500 cycles low, tick every 5000 cycles.
- Reconfigure in IDLE: cfg_div = 4, cfg_high = 1, then en = 1 → clk_out pattern 1,0,0,0 repeating; tick on every 4th cycle.
- Mid-period reconfigure: running div = 10/high = 5, accept div = 6/high = 3 at count = 2 → busy = 1 and cfg_ready = 0 until wrap. The old 10-cycle period completes, then 3 high/3 low; busy returns to 0. A second cfg_valid during pend is not accepted.
- Boundary-cycle accept: offer div = 8/high = 2 exactly when count == div_r-1 → the next period is already 8 cycles with 2 high; busy never asserts.
- Invalid configs: cfg_div = 1; cfg_div = 6 with cfg_high = 0; cfg_div = 6 with cfg_high = 6 → each gives a single-cycle cfg_err; output period unchanged.
- Graceful stop: en = 0 at count = 3 of a 10-cycle period → runs to count = 9 with tick, then IDLE with clk_out = 0. A re-enable at count = 5 instead gives continuous output.
